// File: rtl/uart_rx_frame_parser.sv
// UART receive-side frame parser: validates header/command/length/payload/CRC-8
// frames, streams THETA_BYTES-wide words and applies pipeline enable on a good CRC.
module uart_rx_frame_parser #(
   parameter int         THETA_BYTES    = 6,
   parameter int         MAX_BURST      = 255,
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter logic [7:0] CRC_POLY       = 8'h07,
   parameter logic [7:0] BYTE_HEADER    = 8'hA5,
   parameter logic [7:0] CMD_SINGLE     = 8'h01,
   parameter logic [7:0] CMD_BURST      = 8'h02,
   parameter logic [7:0] CMD_DISABLE    = 8'h03,
   parameter logic [7:0] CMD_ENABLE     = 8'h04
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [7:0]               i_rx_byte,
   input  logic                     i_rx_byte_valid,
   input  logic                     i_rx_err,
   output logic [7:0]               o_cmd,
   output logic                     o_cmd_valid,
   output logic [7:0]               o_burst_cnt,
   output logic                     o_burst_cnt_valid,
   output logic [THETA_BYTES*8-1:0] o_theta,
   output logic                     o_theta_valid,
   output logic                     o_pipeline_en,
   output logic                     o_frame_done,
   output logic                     o_frame_err,
   output logic [2:0]               o_err_code,
   output logic                     o_busy
);

   localparam int W   = THETA_BYTES * 8;
   localparam int BCW = (THETA_BYTES > 1) ? $clog2(THETA_BYTES) : 1;
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [BCW-1:0] BYTE_LAST = BCW'(THETA_BYTES - 1);
   localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_RX      = 3'd1;
   localparam logic [2:0] ERR_BAD_CMD = 3'd2;
   localparam logic [2:0] ERR_BAD_LEN = 3'd3;
   localparam logic [2:0] ERR_CRC     = 3'd4;
   localparam logic [2:0] ERR_TIMEOUT = 3'd5;

   typedef enum logic [2:0] {ST_HEADER, ST_CMD, ST_LEN, ST_PAYLOAD, ST_CRC} state_t;

   function automatic logic [7:0] crc8_fold(input logic [7:0] crc, input logic [7:0] b);
      logic [7:0] c;
      c = crc ^ b;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

   function automatic logic [W-1:0] shift_in(input logic [W-1:0] sr, input logic [7:0] b);
      logic [W-1:0] s;
      s          = sr >> 8;
      s[W-1 -: 8] = b;
      return s;
   endfunction

   state_t         state, state_nxt;
   logic [7:0]     crc, crc_nxt;
   logic [BCW-1:0] byte_cnt, byte_cnt_nxt;
   logic [7:0]     word_cnt, word_cnt_nxt;
   logic [TCW-1:0] tmo_cnt, tmo_cnt_nxt;
   logic [7:0]     cmd_q, cmd_q_nxt;
   logic [W-1:0]   theta_sr, theta_sr_nxt;

   logic [7:0]     cmd_nxt, burst_cnt_nxt;
   logic [W-1:0]   theta_nxt;
   logic           cmd_valid_nxt, burst_valid_nxt, theta_valid_nxt;
   logic           pipeline_en_nxt, frame_done_nxt, frame_err_nxt;
   logic [2:0]     err_code_nxt;

   logic           in_frame, take_byte, abort;
   logic [2:0]     abort_code;
   logic [7:0]     crc_fold;
   logic [W-1:0]   sr_shift;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state             <= ST_HEADER;
         byte_cnt          <= '0;
         word_cnt          <= '0;
         tmo_cnt           <= '0;
         o_cmd             <= '0;
         o_cmd_valid       <= 1'b0;
         o_burst_cnt       <= '0;
         o_burst_cnt_valid <= 1'b0;
         o_theta           <= '0;
         o_theta_valid     <= 1'b0;
         o_pipeline_en     <= 1'b1;
         o_frame_done      <= 1'b0;
         o_frame_err       <= 1'b0;
         o_err_code        <= ERR_NONE;
         o_busy            <= 1'b0;
      end else begin
         state             <= state_nxt;
         byte_cnt          <= byte_cnt_nxt;
         word_cnt          <= word_cnt_nxt;
         tmo_cnt           <= tmo_cnt_nxt;
         o_cmd             <= cmd_nxt;
         o_cmd_valid       <= cmd_valid_nxt;
         o_burst_cnt       <= burst_cnt_nxt;
         o_burst_cnt_valid <= burst_valid_nxt;
         o_theta           <= theta_nxt;
         o_theta_valid     <= theta_valid_nxt;
         o_pipeline_en     <= pipeline_en_nxt;
         o_frame_done      <= frame_done_nxt;
         o_frame_err       <= frame_err_nxt;
         o_err_code        <= err_code_nxt;
         o_busy            <= (state_nxt != ST_HEADER);
      end
   end

   // CRC, command and shift register are always rewritten before being consumed
   always_ff @(posedge i_clk) begin
      crc      <= crc_nxt;
      cmd_q    <= cmd_q_nxt;
      theta_sr <= theta_sr_nxt;
   end

   always_comb begin
      state_nxt       = state;
      crc_nxt         = crc;
      byte_cnt_nxt    = byte_cnt;
      word_cnt_nxt    = word_cnt;
      tmo_cnt_nxt     = tmo_cnt;
      cmd_q_nxt       = cmd_q;
      theta_sr_nxt    = theta_sr;
      cmd_nxt         = o_cmd;
      cmd_valid_nxt   = 1'b0;
      burst_cnt_nxt   = o_burst_cnt;
      burst_valid_nxt = 1'b0;
      theta_nxt       = o_theta;
      theta_valid_nxt = 1'b0;
      pipeline_en_nxt = o_pipeline_en;
      frame_done_nxt  = 1'b0;
      frame_err_nxt   = 1'b0;
      err_code_nxt    = ERR_NONE;
      abort           = 1'b0;
      abort_code      = ERR_NONE;

      in_frame  = (state != ST_HEADER);
      take_byte = i_rx_byte_valid && !(in_frame && i_rx_err);
      crc_fold  = crc8_fold(crc, i_rx_byte);
      sr_shift  = shift_in(theta_sr, i_rx_byte);

      if (in_frame) tmo_cnt_nxt = tmo_cnt + 1'b1;
      if (i_rx_byte_valid) tmo_cnt_nxt = '0;

      if (take_byte) begin
         case (state)
            ST_HEADER: begin
               if (i_rx_byte == BYTE_HEADER) begin
                  crc_nxt      = crc8_fold(8'h00, i_rx_byte);
                  byte_cnt_nxt = '0;
                  word_cnt_nxt = '0;
                  state_nxt    = ST_CMD;
               end
            end
            ST_CMD: begin
               crc_nxt   = crc_fold;
               cmd_q_nxt = i_rx_byte;
               cmd_nxt   = i_rx_byte;
               cmd_valid_nxt = 1'b1;
               case (i_rx_byte)
                  CMD_SINGLE: begin
                     word_cnt_nxt = 8'd1;
                     state_nxt    = ST_PAYLOAD;
                  end
                  CMD_BURST:   state_nxt = ST_LEN;
                  CMD_DISABLE: state_nxt = ST_CRC;
                  CMD_ENABLE:  state_nxt = ST_CRC;
                  default: begin
                     cmd_nxt       = o_cmd;
                     cmd_valid_nxt = 1'b0;
                     abort         = 1'b1;
                     abort_code    = ERR_BAD_CMD;
                  end
               endcase
            end
            ST_LEN: begin
               if (i_rx_byte == 8'd0 || int'(i_rx_byte) > MAX_BURST) begin
                  abort      = 1'b1;
                  abort_code = ERR_BAD_LEN;
               end else begin
                  crc_nxt         = crc_fold;
                  word_cnt_nxt    = i_rx_byte;
                  burst_cnt_nxt   = i_rx_byte;
                  burst_valid_nxt = 1'b1;
                  state_nxt       = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               crc_nxt      = crc_fold;
               theta_sr_nxt = sr_shift;
               if (byte_cnt == BYTE_LAST) begin
                  byte_cnt_nxt    = '0;
                  theta_nxt       = sr_shift;
                  theta_valid_nxt = 1'b1;
                  word_cnt_nxt    = word_cnt - 8'd1;
                  if (word_cnt == 8'd1) state_nxt = ST_CRC;
               end else begin
                  byte_cnt_nxt = byte_cnt + 1'b1;
               end
            end
            ST_CRC: begin
               state_nxt = ST_HEADER;
               crc_nxt   = 8'h00;
               if (crc_fold == 8'h00) begin
                  frame_done_nxt = 1'b1;
                  if (cmd_q == CMD_DISABLE) pipeline_en_nxt = 1'b0;
                  if (cmd_q == CMD_ENABLE)  pipeline_en_nxt = 1'b1;
               end else begin
                  abort      = 1'b1;
                  abort_code = ERR_CRC;
               end
            end
            default: state_nxt = ST_HEADER;
         endcase
      end

      if (in_frame && !i_rx_byte_valid && tmo_cnt == TMO_LAST) begin
         abort      = 1'b1;
         abort_code = ERR_TIMEOUT;
      end
      // A framing error outranks both a simultaneous byte and a timeout
      if (in_frame && i_rx_err) begin
         abort      = 1'b1;
         abort_code = ERR_RX;
      end

      if (abort) begin
         state_nxt     = ST_HEADER;
         crc_nxt       = 8'h00;
         byte_cnt_nxt  = '0;
         word_cnt_nxt  = '0;
         tmo_cnt_nxt   = '0;
         frame_err_nxt = 1'b1;
         err_code_nxt  = abort_code;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser: stimulus pushes expected events into a
// scoreboard queue, a negedge monitor pops and compares each output pulse.
module tb_uart_rx_frame_parser;

   localparam int W  = 48;
   localparam int T  = 40;
   localparam int MB = 5;

   localparam int K_CMD   = 0;
   localparam int K_BURST = 1;
   localparam int K_THETA = 2;
   localparam int K_DONE  = 3;
   localparam int K_ERR   = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   rx_byte;
   logic         rx_byte_valid;
   logic         rx_err;
   logic [7:0]   cmd;
   logic         cmd_valid;
   logic [7:0]   burst_cnt;
   logic         burst_cnt_valid;
   logic [W-1:0] theta;
   logic         theta_valid;
   logic         pipeline_en;
   logic         frame_done;
   logic         frame_err;
   logic [2:0]   err_code;
   logic         busy;

   uart_rx_frame_parser #(
      .THETA_BYTES(6), .MAX_BURST(MB), .TIMEOUT_CYCLES(T)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_rx_byte(rx_byte), .i_rx_byte_valid(rx_byte_valid), .i_rx_err(rx_err),
      .o_cmd(cmd), .o_cmd_valid(cmd_valid),
      .o_burst_cnt(burst_cnt), .o_burst_cnt_valid(burst_cnt_valid),
      .o_theta(theta), .o_theta_valid(theta_valid),
      .o_pipeline_en(pipeline_en), .o_frame_done(frame_done),
      .o_frame_err(frame_err), .o_err_code(err_code), .o_busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           kind;
      logic [W-1:0] val;
      int           stamp;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         last_s = 0;
   logic [7:0] run_crc = 8'h00;

   function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] b);
      logic [7:0] r;
      logic       fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[7] ^ b[i];
         r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return r;
   endfunction

   task automatic expect_ev(input int kind, input logic [W-1:0] val, input int stamp);
      exp_t e;
      e.kind  = kind;
      e.val   = val;
      e.stamp = stamp;
      sb.push_back(e);
   endtask

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic mon(input int kind, input logic [W-1:0] val);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_pulse: kind %0d value %0h at cycle %0d, required none", kind, val, cyc);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.val !== val || e.stamp != cyc) begin
            errors++;
            $display("FAIL event: got kind %0d value %0h cycle %0d, required kind %0d value %0h cycle %0d",
                     kind, val, cyc, e.kind, e.val, e.stamp);
         end
      end
   endtask

   always @(negedge clk) begin
      if (cmd_valid)       mon(K_CMD,   W'(cmd));
      if (burst_cnt_valid) mon(K_BURST, W'(burst_cnt));
      if (theta_valid)     mon(K_THETA, theta);
      if (frame_done)      mon(K_DONE,  '0);
      if (frame_err)       mon(K_ERR,   W'(err_code));
   end

   task automatic send(input logic [7:0] b);
      rx_byte       = b;
      rx_byte_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_byte_valid = 1'b0;
      last_s        = cyc;
   endtask

   task automatic send_c(input logic [7:0] b);
      send(b);
      run_crc = crc_upd(run_crc, b);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start(input logic [7:0] c);
      run_crc = 8'h00;
      send_c(8'hA5);
      send_c(c);
      expect_ev(K_CMD, W'(c), last_s);
   endtask

   task automatic ctrl_frame(input logic [7:0] c, input logic [7:0] crc_b);
      send(8'hA5);
      send(c);
      expect_ev(K_CMD, W'(c), last_s);
      send(crc_b);
   endtask

   logic [W-1:0] bw [3];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bw[0] = 48'h060504030201;
      bw[1] = 48'h0C0B0A090807;
      bw[2] = 48'h1211100F0E0D;
      rst = 1'b1; rx_byte = 8'h00; rx_byte_valid = 1'b0; rx_err = 1'b0;
      idle(3);
      rst = 1'b0;
      check("rst_pipeline_en", W'(pipeline_en), W'(1));
      check("rst_busy", W'(busy), '0);
      check("rst_theta", theta, '0);
      check("rst_cmd", W'(cmd), '0);
      check("rst_err_code", W'(err_code), '0);

      // Disable, bad-CRC enable, good enable
      send(8'hA5);
      check("busy_after_hdr", W'(busy), W'(1));
      send(8'h03); expect_ev(K_CMD, W'(8'h03), last_s);
      send(8'h50); expect_ev(K_DONE, '0, last_s);
      check("disable_pipeline_en", W'(pipeline_en), '0);
      check("busy_after_done", W'(busy), '0);
      ctrl_frame(8'h04, 8'h44); expect_ev(K_ERR, W'(4), last_s);
      check("badcrc_pipeline_hold", W'(pipeline_en), '0);
      ctrl_frame(8'h04, 8'h45); expect_ev(K_DONE, '0, last_s);
      check("enable_pipeline_en", W'(pipeline_en), W'(1));

      // Reset mid-payload after disabling
      ctrl_frame(8'h03, 8'h50); expect_ev(K_DONE, '0, last_s);
      start(8'h01);
      send_c(8'h11); send_c(8'h22); send_c(8'h33);
      rst = 1'b1;
      idle(2);
      check("rst_mid_no_err", W'(frame_err), '0);
      rst = 1'b0;
      check("rst_mid_pipeline_en", W'(pipeline_en), W'(1));
      check("rst_mid_busy", W'(busy), '0);
      idle(3);

      // Single word, good then corrupted CRC
      for (int k = 0; k < 2; k++) begin
         start(8'h01);
         send_c(8'h11); send_c(8'h22); send_c(8'h33);
         send_c(8'h44); send_c(8'h55); send_c(8'h66);
         expect_ev(K_THETA, 48'h665544332211, last_s);
         send(run_crc ^ ((k == 1) ? 8'h01 : 8'h00));
         if (k == 0) expect_ev(K_DONE, '0, last_s);
         else        expect_ev(K_ERR, W'(4), last_s);
      end
      check("single_theta_hold", theta, 48'h665544332211);

      // Header value inside payload is data
      start(8'h01);
      send_c(8'hA5); send_c(8'h01); send_c(8'h02);
      send_c(8'h03); send_c(8'h04); send_c(8'hA5);
      expect_ev(K_THETA, 48'hA504030201A5, last_s);
      send(run_crc); expect_ev(K_DONE, '0, last_s);

      // Burst of three words, then bad lengths
      start(8'h02);
      send_c(8'h03); expect_ev(K_BURST, W'(8'h03), last_s);
      for (int i = 1; i <= 18; i++) begin
         send_c(8'(i));
         if (i % 6 == 0) expect_ev(K_THETA, bw[i/6-1], last_s);
      end
      send(run_crc); expect_ev(K_DONE, '0, last_s);
      start(8'h02);
      send(8'h00); expect_ev(K_ERR, W'(3), last_s);
      start(8'h02);
      send(8'(MB + 1)); expect_ev(K_ERR, W'(3), last_s);
      check("busy_after_badlen", W'(busy), '0);

      // Timeout, then recovery; then a byte arriving on the last allowed cycle
      start(8'h01);
      send_c(8'h11);
      expect_ev(K_ERR, W'(5), last_s + T);
      idle(T);
      check("timeout_busy", W'(busy), '0);
      ctrl_frame(8'h04, 8'h45); expect_ev(K_DONE, '0, last_s);
      start(8'h01);
      send_c(8'h11);
      idle(T - 1);
      send_c(8'h22); send_c(8'h33); send_c(8'h44); send_c(8'h55); send_c(8'h66);
      expect_ev(K_THETA, 48'h665544332211, last_s);
      send(run_crc); expect_ev(K_DONE, '0, last_s);

      // Bad command, framing error in idle and inside payload
      send(8'hA5);
      send(8'h7F); expect_ev(K_ERR, W'(2), last_s);
      rx_err = 1'b1; idle(1); rx_err = 1'b0;
      check("hdr_rx_err_busy", W'(busy), '0);
      start(8'h01);
      send_c(8'h11); send_c(8'h22); send_c(8'h33);
      rx_err = 1'b1;
      send(8'h44); expect_ev(K_ERR, W'(1), last_s);
      rx_err = 1'b0;
      ctrl_frame(8'h04, 8'h45); expect_ev(K_DONE, '0, last_s);

      // Back-to-back frames without idle cycles
      ctrl_frame(8'h03, 8'h50); expect_ev(K_DONE, '0, last_s);
      check("b2b_disable", W'(pipeline_en), '0);
      ctrl_frame(8'h04, 8'h45); expect_ev(K_DONE, '0, last_s);
      check("b2b_enable", W'(pipeline_en), W'(1));

      idle(5);
      check("scoreboard_empty", W'(sb.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
